// File: rtl/cdc_rx_pkg.sv
// ---------------------------------------------------------------------------
// cdc_rx_pkg
// Shared definitions for the toggle-handshake CDC receiver.
//   state_t      : receiver FSM states (IDLE = nothing held, FULL = payload held)
//   SYNC_STAGES  : request synchronizer depth, 2 by default, 3 when the
//                  build macro CDC_RX_SYNC3_EN is defined
//   COUNT_W      : width of the completed-transfer counter
// ---------------------------------------------------------------------------
package cdc_rx_pkg;

    localparam int COUNT_W = 16;

`ifdef CDC_RX_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// ---------------------------------------------------------------------------
// cdc_sync_bit
// Multi-flop synchronizer for a single level/toggle signal entering the
// clkB domain.
//   STAGES     : number of flops in the chain (>= 2)
//   clkB       : destination clock
//   reset      : asynchronous active-high reset, clears every flop
//   async_bit  : signal from the foreign domain
//   sync_bit   : synchronized copy (last flop of the chain)
// ---------------------------------------------------------------------------
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clkB,
    input  logic reset,
    input  logic async_bit,
    output logic sync_bit
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clkB or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_bit};
        end
    end

    assign sync_bit = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// ---------------------------------------------------------------------------
// cdc_handshake_rx
// Receive side of a two-phase (toggle) request/acknowledge CDC handshake.
// A toggle on io_req_async announces a new payload on io_data_async; once
// the synchronized request differs from the local ack, the payload is
// captured and offered downstream with valid/ready. Acceptance toggles the
// acknowledge back to the source and bumps a wrapping transfer counter.
//
// Build option: define CDC_RX_SYNC3_EN for a 3-flop request synchronizer
// (adds one cycle of request-to-valid latency); default is 2 flops.
//
// Ports
//   clkB          in   1      sole clock, rising edge
//   reset         in   1      asynchronous active-high reset
//   io_req_async  in   1      toggle request from the foreign domain
//   io_data_async in   WIDTH  payload, stable while req != ack
//   io_ack        out  1      toggle acknowledge to the source
//   io_out_valid  out  1      captured payload available
//   io_out_ready  in   1      downstream accepts payload
//   io_out_data   out  WIDTH  captured payload
//   io_count      out  16     completed-transfer count (wraps)
// ---------------------------------------------------------------------------
module cdc_handshake_rx
    import cdc_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clkB,
    input  logic               reset,
    input  logic               io_req_async,
    input  logic [WIDTH-1:0]   io_data_async,
    output logic               io_ack,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic [WIDTH-1:0]   io_out_data,
    output logic [COUNT_W-1:0] io_count
);

    state_t               state;
    state_t               next_state;
    logic                 req_s;
    logic                 ack_q;
    logic [WIDTH-1:0]     data_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 capture;
    logic                 accept;

    // Only the request crosses through a synchronizer; the payload is
    // sampled directly because the source holds it while req != ack.
    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clkB      (clkB),
        .reset     (reset),
        .async_bit (io_req_async),
        .sync_bit  (req_s)
    );

    // State register
    always_ff @(posedge clkB or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Further request toggles while FULL are simply not
    // looked at; they are picked up after the return to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_s != ack_q) next_state = FULL;
            FULL: if (io_out_ready)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. Valid is a pure function of the registered state, so it
    // never depends combinationally on io_out_ready.
    always_comb begin
        io_out_valid = 1'b0;
        capture      = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: capture = (req_s != ack_q);
            FULL: begin
                io_out_valid = 1'b1;
                accept       = io_out_ready;
            end
            default: ;
        endcase
    end

    // Payload, acknowledge and counter registers. Reset drops any held
    // payload without toggling the acknowledge.
    always_ff @(posedge clkB or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            ack_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (capture) begin
                data_q <= io_data_async;
            end
            if (accept) begin
                ack_q   <= ~ack_q;
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign io_ack      = ack_q;
    assign io_out_data = data_q;
    assign io_count    = count_q;

endmodule

// File: doc/cdc_handshake_rx.md
CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 SHALL have parameter: WIDTH, 8, payload width in bits (1..64).
REQ-002 SHALL have port: clkB  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: io_req_async  input  1  toggle request from foreign domain; asynchronous to clkB.
REQ-005 SHALL have port: io_data_async  input  WIDTH  payload; held stable by the source while io_req_async != io_ack.
REQ-006 SHALL have port: io_ack  output  1  toggle acknowledge returned to the source.
REQ-007 SHALL have port: io_out_valid  output  1  captured payload available.
REQ-008 SHALL have port: io_out_ready  input  1  downstream accepts payload.
REQ-009 SHALL have port: io_out_data  output  WIDTH  captured payload.
REQ-010 SHALL have port: io_count  output  16  completed-transfer count.

Function
REQ-011 SHALL pass io_req_async through a synchronizer chain, 2 flops by default; its last stage is req_s.
REQ-012 SHALL drive io_ack directly from a register ack_q.
REQ-013 SHALL implement FSM states IDLE and FULL.
REQ-014 In IDLE with req_s != ack_q, SHALL capture io_data_async into io_out_data, set io_out_valid=1, enter FULL on the same edge.
REQ-015 In IDLE with req_s == ack_q, SHALL hold all state.
REQ-016 In FULL with io_out_ready=1, SHALL clear io_out_valid, toggle ack_q, increment io_count, return to IDLE on the same edge.
REQ-017 In FULL with io_out_ready=0, SHALL hold io_out_data, io_out_valid and ack_q unchanged, with no timeout.
REQ-018 io_out_data SHALL be sampled only on the IDLE->FULL edge and never otherwise change.
REQ-019 Latency: a req toggle first sampled at edge E0 SHALL produce io_out_valid=1 after edge E2 (E3 with CDC_RX_SYNC3_EN).
REQ-020 io_count SHALL wrap from 0xFFFF to 0x0000.
REQ-021 A req toggle arriving while in FULL SHALL be ignored until the return to IDLE; it is not a protocol error.
REQ-022 Back-to-back transfers: with req_s already != ack_q on return to IDLE, capture SHALL occur on the next edge, giving a minimum of 2 cycles per transfer.
REQ-023 io_out_valid SHALL NOT depend combinationally on io_out_ready.

Reset
REQ-024 Asserting reset SHALL immediately clear synchronizer flops, ack_q, io_out_valid, io_out_data and io_count to 0, and set state to IDLE.
REQ-025 Reset mid-transfer SHALL discard the held payload without toggling io_ack.
REQ-026 If io_req_async=1 after reset release, SHALL treat it as a pending request once synchronized.

Configuration
REQ-027 Macro CDC_RX_SYNC3_EN defined: synchronizer depth SHALL be 3 flops and all req-to-valid latencies SHALL grow by one cycle.
REQ-028 Macro CDC_RX_SYNC3_EN undefined: synchronizer depth SHALL be 2 flops.

Structure
REQ-029 Package cdc_rx_pkg SHALL hold the FSM state enum, the SYNC_STAGES constant (selected by the macro) and the COUNT_W=16 constant.
REQ-030 The synchronizer SHALL be a separate sub-module cdc_sync_bit, parameterized by depth, clocked by clkB and reset by reset.
REQ-031 Only the req path SHALL be synchronized; io_data_async SHALL be sampled directly under the REQ-005 stability guarantee.

Verification
REQ-032 Single transfer: data=0xA5, req 0->1, ready=1 -> valid high after E2, out_data=0xA5, ack 0->1 on the next edge, count=1.
REQ-033 Backpressure: ready=0 for 10 cycles after valid -> valid, out_data and ack stable for 10 cycles; ready=1 -> ack toggles, count increments once.
REQ-034 Streaming: 5 toggles, each issued as soon as ack matches, ready=1 -> payloads 0x01..0x05 delivered in order, ack toggles 5 times, count=5.
REQ-035 Reset in FULL: data=0x3C captured, reset pulsed -> valid=0, out_data=0, ack=0, count=0 at once; a pending req=1 re-captures after sync.
REQ-036 Wrap: preload 0xFFFF transfers (forced or run) -> next transfer gives count=0x0000.
REQ-037 Macro build: rerun REQ-032 with CDC_RX_SYNC3_EN -> valid high after E3.
